// File: rtl/gb_dma_pkg.sv
// Shared types and constants for the OAM DMA engine.
//   dma_state_e : transfer FSM states
//   OAM_LEN     : bytes copied per transfer
//   ECHO_BASE   : first register value that lands in echo RAM
//   ECHO_OFFSET : distance from an echo page down to its work-RAM page
//   src_page()  : maps a FF46 value to the real source page
package gb_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } dma_state_e;

  localparam int unsigned OAM_LEN     = 160;
  localparam logic [7:0]  ECHO_BASE   = 8'hE0;
  localparam logic [7:0]  ECHO_OFFSET = 8'h20;

  // Echo RAM (E0-FF) aliases work RAM 0x2000 lower.
  function automatic logic [7:0] src_page(input logic [7:0] reg_val);
    return (reg_val >= ECHO_BASE) ? 8'(reg_val - ECHO_OFFSET) : reg_val;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies LENGTH bytes from page FF46 (echo-mapped) into
// sprite attribute RAM, one byte per M-cycle clock-enable tick.
// Ports:
//   clk_sys, reset       : system clock, async active-high reset
//   ce                   : M-cycle clock enable
//   reg_wr, reg_din      : CPU write of FF46 (qualified by ce)
//   reg_dout             : FF46 readback
//   src_addr, src_rd     : source read request (data returns next ce tick)
//   src_data             : source read data
//   oam_addr/data/wren   : OAM RAM write port
//   active               : transfer in progress (START, XFER, DRAIN)
//   cpu_block            : CPU external bus blocked (XFER, DRAIN)
module oam_dma
  import gb_dma_pkg::*;
#(
  parameter int unsigned LENGTH = OAM_LEN,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce,
  input  logic              reg_wr,
  input  logic [7:0]        reg_din,
  output logic [7:0]        reg_dout,
  output logic [15:0]       src_addr,
  output logic              src_rd,
  input  logic [7:0]        src_data,
  output logic [ADDR_W-1:0] oam_addr,
  output logic [7:0]        oam_data,
  output logic              oam_wren,
  output logic              active,
  output logic              cpu_block
);

  // One extra bit so idx can reach LENGTH=256 and still terminate.
  localparam int unsigned        IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0]   LEN_C = IDX_W'(LENGTH);

  dma_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        reg_q, reg_d;
  logic [15:0]       src_addr_q, src_addr_d;
  logic              src_rd_q, src_rd_d;
  logic [ADDR_W-1:0] oam_addr_q, oam_addr_d;
  logic [7:0]        oam_data_q, oam_data_d;
  logic              oam_wren_q, oam_wren_d;
  logic              active_q, active_d;
  logic              cpu_block_q, cpu_block_d;
  logic [7:0]        page;

  assign page = src_page(reg_q);

  // State and output registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      reg_q       <= 8'h00;
      src_addr_q  <= 16'h0000;
      src_rd_q    <= 1'b0;
      oam_addr_q  <= '0;
      oam_data_q  <= 8'h00;
      oam_wren_q  <= 1'b0;
      active_q    <= 1'b0;
      cpu_block_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      reg_q       <= reg_d;
      src_addr_q  <= src_addr_d;
      src_rd_q    <= src_rd_d;
      oam_addr_q  <= oam_addr_d;
      oam_data_q  <= oam_data_d;
      oam_wren_q  <= oam_wren_d;
      active_q    <= active_d;
      cpu_block_q <= cpu_block_d;
    end
  end

  // Next-state logic; write enable defaults low so it pulses for one clock.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    reg_d      = reg_q;
    src_addr_d = src_addr_q;
    src_rd_d   = src_rd_q;
    oam_addr_d = oam_addr_q;
    oam_data_d = oam_data_q;
    oam_wren_d = 1'b0;

    if (ce) begin
      if (reg_wr) begin
        // Restart: any write due on this tick is dropped.
        reg_d    = reg_din;
        idx_d    = '0;
        src_rd_d = 1'b0;
        state_d  = START;
      end else begin
        unique case (state_q)
          IDLE: ;
          START: begin
            src_rd_d   = 1'b1;
            src_addr_d = {page, 8'h00};
            idx_d      = IDX_W'(1);
            state_d    = XFER;
          end
          XFER: begin
            // src_data holds byte idx-1, requested on the previous tick.
            oam_addr_d = ADDR_W'(idx_q - IDX_W'(1));
            oam_data_d = src_data;
            oam_wren_d = 1'b1;
            if (idx_q < LEN_C) begin
              src_rd_d   = 1'b1;
              src_addr_d = {page, 8'(idx_q)};
              idx_d      = idx_q + IDX_W'(1);
            end else begin
              src_rd_d = 1'b0;
              state_d  = DRAIN;
            end
          end
          DRAIN: state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end

    active_d    = (state_d != IDLE);
    cpu_block_d = (state_d == XFER) || (state_d == DRAIN);
  end

  assign reg_dout  = reg_q;
  assign src_addr  = src_addr_q;
  assign src_rd    = src_rd_q;
  assign oam_addr  = oam_addr_q;
  assign oam_data  = oam_data_q;
  assign oam_wren  = oam_wren_q;
  assign active    = active_q;
  assign cpu_block = cpu_block_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: ce on every 4th clock, source memory modelled
// as a 64 KiB array read at the registered src_addr.
module tb_oam_dma;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ce;
  logic        reg_wr;
  logic [7:0]  reg_din;
  logic [7:0]  reg_dout;
  logic [15:0] src_addr;
  logic        src_rd;
  logic [7:0]  src_data;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        oam_wren;
  logic        active;
  logic        cpu_block;

  oam_dma dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ce       (ce),
    .reg_wr   (reg_wr),
    .reg_din  (reg_din),
    .reg_dout (reg_dout),
    .src_addr (src_addr),
    .src_rd   (src_rd),
    .src_data (src_data),
    .oam_addr (oam_addr),
    .oam_data (oam_data),
    .oam_wren (oam_wren),
    .active   (active),
    .cpu_block(cpu_block)
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0] mem [0:65535];
  assign src_data = mem[src_addr];

  int errors = 0;
  int checks = 0;
  int act_ticks;
  int pulse_bad;
  logic [15:0] wr_q[$];
  logic [15:0] rd_q[$];

  // Snapshot taken just after each ce edge.
  logic        s_act, s_blk, s_rd, s_wren;
  logic [15:0] s_saddr;
  logic [7:0]  s_oaddr, s_odata, s_rdout;

  typedef struct {
    logic        wr;
    logic [7:0]  din;
    logic        act, blk, rd, wren;
    logic [15:0] saddr;
    logic [7:0]  oaddr, odata, rdout;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [7:0] exp_byte(input logic [7:0] page, input logic [7:0] i);
    return (page == 8'hC1) ? (i ^ 8'h5A) : (i ^ page);
  endfunction

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    end
  endtask

  // One M-cycle: ce edge followed by three clocks with ce low.
  task automatic tick(input logic wr, input logic [7:0] din);
    @(negedge clk_sys);
    ce = 1'b1; reg_wr = wr; reg_din = din;
    @(posedge clk_sys); #1;
    s_act = active; s_blk = cpu_block; s_rd = src_rd; s_wren = oam_wren;
    s_saddr = src_addr; s_oaddr = oam_addr; s_odata = oam_data; s_rdout = reg_dout;
    if (oam_wren) wr_q.push_back({oam_addr, oam_data});
    if (src_rd) rd_q.push_back(src_addr);
    if (active) act_ticks++;
    @(negedge clk_sys);
    ce = 1'b0; reg_wr = 1'b0;
    repeat (3) begin
      @(posedge clk_sys); #1;
      if (oam_wren) pulse_bad++;
    end
  endtask

  task automatic clear_logs();
    wr_q.delete(); rd_q.delete();
    act_ticks = 0; pulse_bad = 0;
  endtask

  task automatic run_until_idle(input string name);
    int n;
    n = 0;
    while (active && n < 400) begin
      tick(1'b0, 8'h00);
      n++;
    end
    if (active) check({name, "_timeout"}, 32'(active), 32'd0);
  endtask

  task automatic run_until_writes(input int target);
    int n;
    n = 0;
    while (wr_q.size() < target && n < 400) begin
      tick(1'b0, 8'h00);
      n++;
    end
    check("wait_writes", 32'(wr_q.size()), 32'(target));
  endtask

  // Verifies a complete transfer recorded in the logs.
  task automatic check_xfer(input string name, input logic [7:0] page);
    int bad_w, bad_r;
    logic [15:0] ew, er;
    bad_w = 0; bad_r = 0;
    check({name, "_wcnt"}, 32'(wr_q.size()), 32'd160);
    check({name, "_rcnt"}, 32'(rd_q.size()), 32'd160);
    for (int i = 0; i < 160 && i < wr_q.size(); i++) begin
      ew = {8'(i), exp_byte(page, 8'(i))};
      if (wr_q[i] !== ew) begin
        if (bad_w == 0) $display("FAIL %s_wr[%0d]: got %h expected %h", name, i, wr_q[i], ew);
        bad_w++;
      end
    end
    for (int i = 0; i < 160 && i < rd_q.size(); i++) begin
      er = {page, 8'(i)};
      if (rd_q[i] !== er) begin
        if (bad_r == 0) $display("FAIL %s_rd[%0d]: got %h expected %h", name, i, rd_q[i], er);
        bad_r++;
      end
    end
    check({name, "_wdata_bad"}, 32'(bad_w), 32'd0);
    check({name, "_raddr_bad"}, 32'(bad_r), 32'd0);
    check({name, "_pulse_bad"}, 32'(pulse_bad), 32'd0);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_reg_dout"}, 32'(reg_dout), 32'h00);
    check({name, "_src_addr"}, 32'(src_addr), 32'h0000);
    check({name, "_src_rd"}, 32'(src_rd), 32'd0);
    check({name, "_oam"}, 32'({oam_addr, oam_data, 6'(0), oam_wren}), 32'd0);
    check({name, "_act_blk"}, 32'({active, cpu_block}), 32'd0);
  endtask

  initial begin
    logic [15:0] h_saddr;
    logic [7:0]  h_oaddr;
    logic        h_rd;
    int          n_idle_wren;

    for (int a = 0; a < 65536; a++) mem[a] = exp_byte(8'(a >> 8), 8'(a));

    vecs[0] = '{1'b1, 8'hC1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 8'hC1};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'hC100, 8'h00, 8'h00, 8'hC1};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 16'hC101, 8'h00, 8'h5A, 8'hC1};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 16'hC102, 8'h01, 8'h5B, 8'hC1};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 16'hC103, 8'h02, 8'h58, 8'hC1};

    reset = 1'b1; ce = 1'b0; reg_wr = 1'b0; reg_din = 8'h00;
    repeat (3) @(posedge clk_sys);
    #1 check_reset_vals("reset");
    @(negedge clk_sys) reset = 1'b0;

    // Basic copy from page C1, opening ticks table-driven.
    clear_logs();
    for (int v = 0; v < 5; v++) begin
      tick(vecs[v].wr, vecs[v].din);
      check($sformatf("vec%0d_act", v), 32'(s_act), 32'(vecs[v].act));
      check($sformatf("vec%0d_blk", v), 32'(s_blk), 32'(vecs[v].blk));
      check($sformatf("vec%0d_rd", v), 32'(s_rd), 32'(vecs[v].rd));
      check($sformatf("vec%0d_wren", v), 32'(s_wren), 32'(vecs[v].wren));
      check($sformatf("vec%0d_saddr", v), 32'(s_saddr), 32'(vecs[v].saddr));
      check($sformatf("vec%0d_oaddr", v), 32'(s_oaddr), 32'(vecs[v].oaddr));
      check($sformatf("vec%0d_odata", v), 32'(s_odata), 32'(vecs[v].odata));
      check($sformatf("vec%0d_rdout", v), 32'(s_rdout), 32'(vecs[v].rdout));
    end
    run_until_idle("basic");
    check_xfer("basic", 8'hC1);
    check("basic_active_ticks", 32'(act_ticks), 32'd162);
    check("basic_reg_dout", 32'(reg_dout), 32'hC1);
    check("basic_idle_blk", 32'(cpu_block), 32'd0);

    // Back-to-back: write on the very next tick after active fell.
    clear_logs();
    tick(1'b1, 8'hC0);
    check("b2b_start_act", 32'(s_act), 32'd1);
    check("b2b_start_blk", 32'(s_blk), 32'd0);
    tick(1'b0, 8'h00);
    check("b2b_xfer_blk", 32'(s_blk), 32'd1);
    run_until_idle("b2b");
    check_xfer("b2b", 8'hC0);
    check("b2b_active_ticks", 32'(act_ticks), 32'd162);

    // Echo mapping: FE reads from DE.
    clear_logs();
    tick(1'b1, 8'hFE);
    run_until_idle("echo");
    check_xfer("echo", 8'hDE);
    check("echo_reg_dout", 32'(reg_dout), 32'hFE);

    // Restart on the tick that would write byte 50.
    clear_logs();
    tick(1'b1, 8'hC0);
    run_until_writes(50);
    clear_logs();
    tick(1'b1, 8'hC2);
    check("restart_no_wren", 32'(s_wren), 32'd0);
    check("restart_reg_dout", 32'(s_rdout), 32'hC2);
    run_until_idle("restart");
    check_xfer("restart", 8'hC2);
    check("restart_active_ticks", 32'(act_ticks), 32'd162);

    // ce held low for 20 clocks mid-transfer.
    clear_logs();
    tick(1'b1, 8'hC1);
    run_until_writes(80);
    h_saddr = src_addr; h_oaddr = oam_addr; h_rd = src_rd;
    n_idle_wren = 0;
    repeat (20) begin
      @(posedge clk_sys); #1;
      if (oam_wren) n_idle_wren++;
    end
    check("ceg_no_wren", 32'(n_idle_wren), 32'd0);
    check("ceg_src_addr", 32'(src_addr), 32'(h_saddr));
    check("ceg_oam_addr", 32'(oam_addr), 32'(h_oaddr));
    check("ceg_src_rd", 32'(src_rd), 32'(h_rd));
    check("ceg_state", 32'({active, cpu_block}), 32'b11);
    run_until_idle("ceg");
    check_xfer("ceg", 8'hC1);
    check("ceg_active_ticks", 32'(act_ticks), 32'd162);

    // Async reset between clock edges at byte 80.
    clear_logs();
    tick(1'b1, 8'hC2);
    run_until_writes(80);
    @(negedge clk_sys); #2;
    reset = 1'b1;
    #1 check_reset_vals("mid_reset");
    @(negedge clk_sys) reset = 1'b0;
    clear_logs();
    tick(1'b1, 8'hC1);
    run_until_idle("post_reset");
    check_xfer("post_reset", 8'hC1);
    check("post_reset_active_ticks", 32'(act_ticks), 32'd162);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- OAM DMA engine for the Game Boy core. It copies LENGTH bytes from a CPU-visible source page into sprite attribute RAM.
- It reads the source through a synchronous-read memory port and drives the write port (address_a/data_a/wren_a) of the 8-bit dual-port OAM RAM.
- It advances one byte per M-cycle clock-enable tick.
- It exposes the FF46 register and a bus-block flag to the CPU arbiter.

Parameters:
- LENGTH, 160, bytes per transfer; must be ≤ 256.
- ADDR_W, 8, OAM RAM address width; matches the RAM widthad_a.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous active-high reset
- ce  in  1  M-cycle clock enable; all state advances only on clk_sys edges with ce=1
- reg_wr  in  1  CPU write strobe for FF46, qualified by ce
- reg_din  in  8  CPU write data (source page high byte)
- reg_dout  out  8  FF46 readback, last written value
- src_addr  out  16  source read address
- src_rd  out  1  source read request
- src_data  in  8  source read data; valid on the ce tick after src_rd was issued (1-tick latency)
- oam_addr  out  ADDR_W  OAM RAM write address
- oam_data  out  8  OAM RAM write data
- oam_wren  out  1  OAM RAM write enable
- active  out  1  transfer in progress (START, XFER or DRAIN)
- cpu_block  out  1  CPU external bus blocked (XFER or DRAIN only)

Behaviour:
- Reset values: state=IDLE, idx=0, reg_dout=8'h00, src_addr=16'h0000, src_rd=0, oam_addr=0, oam_data=0, oam_wren=0, active=0, cpu_block=0.
- All outputs are registered.
- States: IDLE, START, XFER, DRAIN.
- Page mapping: if reg ≥ 8'hE0, the source high byte is reg−8'h20 (echo RAM alias); otherwise it is reg. src_addr = {page, idx}.
- reg_wr & ce, in any state:
  - reg_dout<=reg_din, idx<=0, state<=START.
  - This restarts the transfer. Any in-flight write on this tick is suppressed.
- START, ce tick: issue read of byte 0 (src_rd=1, src_addr={page,0}), idx<=1, state<=XFER.
- XFER, ce tick:
  - Write byte idx−1: oam_addr=idx−1, oam_data=src_data, oam_wren=1.
  - If idx<LENGTH: read byte idx and increment idx.
  - Else: src_rd<=0, state<=DRAIN.
- DRAIN: transitional, one tick only. The write of byte LENGTH−1 is issued on entry; on the next ce tick oam_wren<=0 and state<=IDLE.
- oam_wren is high for exactly one clk_sys cycle after each write tick, then 0 until the next ce tick. src_rd holds until the next ce tick.
- Timing from a reg_wr on tick T0:
  - active rises after T0.
  - Byte k is written at tick T0+k+2.
  - The last write is at T0+LENGTH+1; active falls after T0+LENGTH+2.
  - Total: 162 M-cycles for LENGTH=160.
- cpu_block = (state==XFER || state==DRAIN).
- ce=0: everything holds, including reg_wr, which is ignored without ce.
- reset mid-transfer: immediate return to the reset values. OAM is not cleared. Partially written bytes remain.
- idx is ADDR_W+1 bits so that LENGTH=256 terminates correctly.

Decomposition:
- Package gb_dma_pkg:
  - state enum type (IDLE, START, XFER, DRAIN)
  - OAM_LEN=160
  - ECHO_BASE=8'hE0
  - ECHO_OFFSET=8'h20
- Single module, no sub-module. The counter and FSM are small enough to stay inline.

Test Plan:
- Basic copy:
  - Stimulus: preload page C1 with byte i = i^8'h5A; write FF46=8'hC1 with ce every 4th clk.
  - Required: 160 oam_wren pulses; oam_addr 0..159 in order; oam_data = i^8'h5A; active high for exactly 162 ce ticks; reg_dout=8'hC1.
- Echo mapping:
  - Stimulus: write FF46=8'hFE.
  - Required: src_addr runs 16'hDE00..16'hDE9F; never FExx.
- Restart mid-transfer:
  - Stimulus: write FF46=8'hC0; at byte 50 write FF46=8'hC2.
  - Required: no write on the restart tick; addresses restart at 0 from page C2; total transfer completes 162 ticks after the second write.
- ce gating:
  - Stimulus: hold ce=0 for 20 clks mid-XFER.
  - Required: src_addr, idx and state frozen; no oam_wren; transfer resumes intact.
- Async reset mid-transfer:
  - Stimulus: assert reset between clock edges at byte 80.
  - Required: outputs at reset values immediately; a new FF46 write afterwards performs a full 160-byte copy.
- Back-to-back:
  - Stimulus: a second FF46 write on the tick after active falls.
  - Required: starts normally; cpu_block is low for the START tick in between.
